// File: rtl/rv_pkg.sv
// Shared RV32 integer datapath constants used by the register file slice.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // Architectural x0: reads as zero, writes are discarded.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index -> data mux with x0 forced to zero.
module regfile_read_port
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] regs_i [2**ADDR_WIDTH],
    output logic [DATA_WIDTH-1:0] data_o
);

    // Select the addressed register; x0 is zero regardless of the array contents.
    always_comb begin
        data_o = '0;
        if (addr_i != ADDR_WIDTH'(REG_ZERO)) begin
            data_o = regs_i[addr_i];
        end
    end

endmodule

// File: rtl/register_file.sv
// RV32 integer register file: two combinational read ports, one synchronous write port.
module register_file
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable_3,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] write_data_3,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int unsigned NREGS = 2**ADDR_WIDTH;

    // Only x1..x(NREGS-1) are stored; x0 exists solely as a constant in regs_view.
    logic [DATA_WIDTH-1:0] regs_q    [1:NREGS-1];
    logic [DATA_WIDTH-1:0] regs_d    [1:NREGS-1];
    logic [DATA_WIDTH-1:0] regs_view [NREGS];

    // Write decode: only the addressed non-zero register takes the write data.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (write_enable_3 && (rd == ADDR_WIDTH'(i))) begin
                regs_d[i] = write_data_3;
            end
        end
    end

    // Storage update; synchronous reset clears everything and wins over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Full-index view presented to the read ports, with slot 0 tied to zero.
    always_comb begin
        regs_view[0] = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            regs_view[i] = regs_q[i];
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port_1 (
        .addr_i (rs1),
        .regs_i (regs_view),
        .data_o (rd1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port_2 (
        .addr_i (rs2),
        .regs_i (regs_view),
        .data_o (rd2)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data, monitor compares.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_enable_3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] write_data_3;
    logic [31:0] rd1;
    logic [31:0] rd2;

    typedef struct {
        string       nm;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    register_file #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .write_enable_3 (write_enable_3),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .write_data_3   (write_data_3),
        .rd1            (rd1),
        .rd2            (rd2)
    );

    always #5 clk = ~clk;

    // Monitor: whenever the read ports are presented for sampling, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample_without_expectation rd1=%h rd2=%h", rd1, rd2);
            end else begin
                e = exp_q.pop_front();
                if (rd1 !== e.e1 || rd2 !== e.e2) begin
                    errors++;
                    $display("FAIL %s: got rd1=%h rd2=%h, expected rd1=%h rd2=%h",
                             e.nm, rd1, rd2, e.e1, e.e2);
                end
            end
        end
    end

    // Queue an expectation and ask the monitor to sample right now.
    task automatic expect_now(input string nm, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.nm = nm;
        e.e1 = e1;
        e.e2 = e2;
        exp_q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] e1, input logic [31:0] e2);
        rs1 = a;
        rs2 = b;
        #1;
        expect_now(nm, e1, e2);
    endtask

    // One write (or suppressed write) across a single rising edge.
    task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write_enable_3 = en;
        rd             = a;
        write_data_3   = d;
        @(posedge clk);
        #1;
        write_enable_3 = 1'b0;
    endtask

    task automatic pulse_rst(input logic en, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rst            = 1'b1;
        write_enable_3 = en;
        rd             = a;
        write_data_3   = d;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        write_enable_3 = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        write_enable_3 = 1'b0;
        rs1            = '0;
        rs2            = '0;
        rd             = '0;
        write_data_3   = '0;

        // 1. reset, then every index reads zero
        pulse_rst(1'b0, 5'd0, 32'h0);
        rd_chk("reset_x0", 5'd0, 5'd0, 32'h0, 32'h0);
        for (int i = 1; i < 32; i++) begin
            rd_chk($sformatf("reset_x%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);
        end

        // 2. write to x0 is discarded
        wr(1'b1, 5'd0, 32'hDEADBEEF);
        rd_chk("x0_write_dropped", 5'd0, 5'd0, 32'h0, 32'h0);

        // 3. writes on successive edges, then port pairs
        wr(1'b1, 5'd1,  32'h12345678);
        wr(1'b1, 5'd2,  32'hAABBCCDD);
        wr(1'b1, 5'd3,  32'h99887766);
        wr(1'b1, 5'd31, 32'hFFFFFFFF);
        rd_chk("read_1_2",   5'd1, 5'd2,  32'h12345678, 32'hAABBCCDD);
        rd_chk("read_2_3",   5'd2, 5'd3,  32'hAABBCCDD, 32'h99887766);
        rd_chk("read_3_31",  5'd3, 5'd31, 32'h99887766, 32'hFFFFFFFF);
        rd_chk("read_same",  5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF);
        rd_chk("read_0_31",  5'd0, 5'd31, 32'h0, 32'hFFFFFFFF);
        rd_chk("read_unwritten", 5'd4, 5'd30, 32'h0, 32'h0);

        // 4. write enable low leaves x1 untouched
        wr(1'b0, 5'd1, 32'hDEADBEEF);
        rd_chk("we0_no_change", 5'd1, 5'd2, 32'h12345678, 32'hAABBCCDD);

        // 5. reset clears, and overrides a simultaneous write
        pulse_rst(1'b0, 5'd0, 32'h0);
        rd_chk("rst_clears", 5'd1, 5'd31, 32'h0, 32'h0);
        rd_chk("rst_clears_2_3", 5'd2, 5'd3, 32'h0, 32'h0);
        pulse_rst(1'b1, 5'd5, 32'hCAFEF00D);
        rd_chk("rst_beats_write", 5'd5, 5'd5, 32'h0, 32'h0);

        // 6. read-during-write: old value before the edge, new value after
        @(posedge clk);
        #1;
        rs1            = 5'd10;
        rs2            = 5'd10;
        rd             = 5'd10;
        write_data_3   = 32'h55555555;
        write_enable_3 = 1'b1;
        #8;
        expect_now("rdw_before_edge", 32'h0, 32'h0);
        @(posedge clk);
        #1;
        write_enable_3 = 1'b0;
        expect_now("rdw_after_edge", 32'h55555555, 32'h55555555);
        rd_chk("rdw_neighbour", 5'd9, 5'd11, 32'h0, 32'h0);

        // every queued expectation must have been consumed
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
